bpsk_frame_sync: RTL
====================

Name: bpsk_frame_sync

Overview:
- Sits directly downstream of the BPSK demodulator and consumes its one-bit-per-symbol decisions.
- Searches the hard-decision bit stream for a fixed sync word, then assembles the following payload bits into bytes, MSB first.
- Emits each byte with a one-cycle valid strobe, plus frame start/end markers.
- Optionally resolves the 180-degree BPSK phase ambiguity by also accepting an inverted sync word.

Parameters:
SYNC_WIDTH, 32, sync word length in bits (8..64)
SYNC_WORD, 32'h1ACFFC1D, sync pattern, transmitted MSB first
PAYLOAD_BYTES, 4, payload bytes per frame (1..255)

Ports:
clock  input  1  system clock; all state on rising edge
reset_n  input  1  asynchronous, active-low reset
bit_in  input  1  demodulated symbol decision (0/1)
bit_valid  input  1  one-cycle strobe: bit_in is a new symbol this cycle
resync  input  1  synchronous abort: force return to SEARCH
byte_out  output  8  assembled payload byte, held until next byte
byte_valid  output  1  one-cycle strobe: byte_out is new
frame_start  output  1  one-cycle strobe: sync word detected
frame_end  output  1  one-cycle strobe: last byte of frame emitted
locked  output  1  high while in PAYLOAD state
inverted  output  1  current frame locked on inverted sync word

Behaviour:
- Reset (reset_n low, asynchronous) clears the following to 0: all outputs, shift register, fill counter, bit/byte counters. State goes to SEARCH.
- Bits are consumed only on cycles where bit_valid=1. Gaps of any length between strobes are legal.
- State SEARCH:
  - Each accepted bit shifts into a SYNC_WIDTH shift register (new bit at LSB).
  - A fill counter saturates at SYNC_WIDTH.
  - A match is valid only when the fill counter, including the current bit, is >= SYNC_WIDTH. Compare the post-shift value against SYNC_WORD.
  - On match, at the same edge: state goes to PAYLOAD, locked=1, bit and byte counters clear, and frame_start=1 for the following cycle.
  - Overlapping prefixes are handled naturally by the sliding compare.
- State PAYLOAD:
  - Each accepted bit is XORed with the inverted flag, then shifted into the byte assembler, MSB first.
  - On the 8th bit of a byte, byte_out is registered and byte_valid pulses for one cycle. Latency is 1 clock after the edge that accepted the bit.
  - When the byte counter reaches PAYLOAD_BYTES, frame_end pulses in the same cycle as that byte_valid. At the same edge: state returns to SEARCH, locked=0, and the shift register and fill counter clear. The next frame needs a complete fresh sync word.
- Pulse outputs (byte_valid, frame_start, frame_end) are registered and high for exactly one cycle.
- byte_out holds its last value otherwise.
- resync=1 in any state, at that edge:
  - SEARCH state, shift register and fill counter clear; locked=0 and inverted=0.
  - No byte_valid or frame_end is emitted for a partial byte or frame.
  - If bit_valid is high in the same cycle, resync wins and the bit is discarded.
- Reset mid-frame discards the partial frame. No strobes are emitted.
- Width rules:
  - Fill counter: clog2(SYNC_WIDTH+1) bits.
  - Bit counter: 3 bits.
  - Byte counter: 8 bits.
  - No arithmetic is performed on bit_in.

Optional Feature:
Macro SYNC_INVERT_EN.
- Defined:
  - In SEARCH, a post-shift value equal to the bitwise inverse of SYNC_WORD also locks, with the same timing as a normal match.
  - In that case inverted=1 and every payload bit is complemented before assembly.
  - A normal match sets inverted=0. If both compares were ever true simultaneously, the normal match wins.
  - inverted holds for the frame and clears on return to SEARCH, resync, or reset.
- Undefined:
  - The inverse compare is not built. An inverted sync word never locks.
  - inverted is tied to 0 and payload bits are used unmodified.

Test Plan:
1. Defaults. After reset, send bits of 32'h1ACFFC1D then 8'hA5, 8'h3C, 8'h00, 8'hFF, with bit_valid every 3rd clock. Required:
   - frame_start one cycle after the 32nd bit.
   - byte_valid x4 with byte_out A5, 3C, 00, FF.
   - frame_end coincident with the FF strobe.
   - locked=0 afterwards.
2. Send 16'h1ACF then the full 32'h1ACFFC1D, then the payload. Required: exactly one frame_start, after the final sync bit; payload bytes correct.
3. With SYNC_INVERT_EN defined, send 32'hE53003E2 then 8'h5A. Required: frame_start, inverted=1, first byte_out=A5. Without the macro, same stimulus gives no frame_start and locked stays 0.
4. Lock on a frame, send 12 payload bits, then assert resync together with bit_valid. Required:
   - Only the first byte is emitted.
   - No frame_end.
   - locked=0 next cycle.
   - A fresh sync plus 4 bytes then decodes correctly.
5. Lock on a frame, pull reset_n low mid-edge-free (between clocks) during byte 2. Required:
   - All outputs are 0 immediately.
   - No byte_valid after release.
   - 31 bits of 32'h1ACFFC1D alone do not lock.
6. Two back-to-back frames with no gap bits between them. Required: two frame_start, eight byte_valid, two frame_end, in order.

Source files
------------

// File: rtl/bpsk_frame_sync.sv
// Purpose : find a fixed sync word in the BPSK hard-decision stream, then pack the payload bits into bytes, MSB first.
// Latency : each strobe is registered and appears 1 clock after the edge that accepts the bit that causes it.
// Backpr. : none; the block accepts a bit on every cycle where bit_valid=1, and resync aborts at any time.
//
// Ports:
//   clock       system clock, rising edge
//   reset_n     asynchronous active-low reset
//   bit_in      demodulated symbol decision
//   bit_valid   bit_in holds a new symbol this cycle
//   resync      synchronous abort back to SEARCH; it overrides bit_valid
//   byte_out    last assembled payload byte, held between strobes
//   byte_valid  one-cycle strobe: byte_out has a new value
//   frame_start one-cycle strobe: the sync word was just detected
//   frame_end   one-cycle strobe that coincides with the last byte_valid of a frame
//   locked      high while payload bits are being assembled
//   inverted    the current frame locked on the complemented sync word
//
// Optional feature: define SYNC_INVERT_EN to also lock on ~SYNC_WORD.
// This resolves the 180-degree phase ambiguity.
module bpsk_frame_sync #(
    parameter int                    SYNC_WIDTH    = 32,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD     = 32'h1ACFFC1D,
    parameter int                    PAYLOAD_BYTES = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       resync,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_start,
    output logic       frame_end,
    output logic       locked,
    output logic       inverted
);

    localparam int                FW        = $clog2(SYNC_WIDTH + 1);
    localparam logic [FW-1:0]     FILL_FULL = SYNC_WIDTH[FW-1:0];
    localparam logic [7:0]        LAST_BYTE = PAYLOAD_BYTES[7:0];

    typedef enum logic {SEARCH, PAYLOAD} state_t;

    state_t                  state_q;
    logic [SYNC_WIDTH-1:0]   sh_q;
    logic [FW-1:0]           fill_q;
    logic [2:0]              bit_cnt_q;
    logic [7:0]              byte_cnt_q;
    logic [6:0]              asm_q;

    logic [SYNC_WIDTH-1:0]   sh_next;
    logic [FW-1:0]           fill_next;
    logic                    full_next;
    logic                    match;
    logic                    pbit;
    logic [7:0]              asm_next;
    logic [7:0]              byte_cnt_next;

`ifdef SYNC_INVERT_EN
    logic inv_q;
    logic match_inv;
    assign match_inv = full_next && (sh_next == ~SYNC_WORD);
    assign inverted  = inv_q;
    assign pbit      = bit_in ^ inv_q;
`else
    assign inverted  = 1'b0;
    assign pbit      = bit_in;
`endif

    // The compare looks at the window that includes the bit accepted this cycle.
    // This lets the lock happen at the same edge as the last sync bit.
    always_comb begin
        sh_next       = {sh_q[SYNC_WIDTH-2:0], bit_in};
        fill_next     = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
        full_next     = (fill_next == FILL_FULL);
        match         = full_next && (sh_next == SYNC_WORD);
        asm_next      = {asm_q, pbit};
        byte_cnt_next = byte_cnt_q + 8'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SEARCH;
            sh_q        <= '0;
            fill_q      <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            asm_q       <= '0;
            byte_out    <= '0;
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            locked      <= 1'b0;
`ifdef SYNC_INVERT_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            if (resync) begin
                // A partial byte or frame is dropped without any strobe.
                state_q    <= SEARCH;
                sh_q       <= '0;
                fill_q     <= '0;
                bit_cnt_q  <= '0;
                byte_cnt_q <= '0;
                locked     <= 1'b0;
`ifdef SYNC_INVERT_EN
                inv_q      <= 1'b0;
`endif
            end else if (bit_valid) begin
                case (state_q)
                    SEARCH: begin
                        sh_q   <= sh_next;
                        fill_q <= fill_next;
                        if (match) begin
                            state_q     <= PAYLOAD;
                            locked      <= 1'b1;
                            frame_start <= 1'b1;
                            bit_cnt_q   <= '0;
                            byte_cnt_q  <= '0;
`ifdef SYNC_INVERT_EN
                            inv_q       <= 1'b0;
`endif
                        end
`ifdef SYNC_INVERT_EN
                        // Checked second, so the true sync word wins if both compares match.
                        else if (match_inv) begin
                            state_q     <= PAYLOAD;
                            locked      <= 1'b1;
                            frame_start <= 1'b1;
                            bit_cnt_q   <= '0;
                            byte_cnt_q  <= '0;
                            inv_q       <= 1'b1;
                        end
`endif
                    end
                    PAYLOAD: begin
                        asm_q     <= asm_next[6:0];
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_out   <= asm_next;
                            byte_valid <= 1'b1;
                            byte_cnt_q <= byte_cnt_next;
                            if (byte_cnt_next == LAST_BYTE) begin
                                // The next frame needs a complete new sync word,
                                // so the search window starts empty.
                                frame_end  <= 1'b1;
                                state_q    <= SEARCH;
                                locked     <= 1'b0;
                                sh_q       <= '0;
                                fill_q     <= '0;
                                byte_cnt_q <= '0;
`ifdef SYNC_INVERT_EN
                                inv_q      <= 1'b0;
`endif
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule
